// File: rtl/if_id_skid_buffer.sv
// -----------------------------------------------------------------------------
// if_id_skid_buffer
//
// Two-entry skid buffer at the IF->ID pipeline boundary. It carries
// {instruction, PC} pairs from fetch to decode. in_ready is a function of
// registered state only, so decode backpressure (out_ready) never forms a
// combinational path back into the fetch stage. IF freezes on ~in_ready.
//
// Handshake: a beat transfers on an interface in any cycle where its valid and
// ready are both high at the rising clock edge. Valid never depends on ready.
// Once out_valid is high, out_instr/out_pc stay stable until the beat is popped
// or the buffer is flushed. flush drops every entry, and also the same-cycle
// input beat.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active low
//   in_valid   in   fetch presents an instruction
//   in_instr   in   fetched instruction
//   in_pc      in   PC of in_instr
//   in_ready   out  buffer accepts this cycle
//   flush      in   discard all entries (taken branch resolved downstream)
//   out_valid  out  head entry valid toward decode
//   out_instr  out  head instruction, NOP_INSTR when empty
//   out_pc     out  head PC, 0 when empty
//   out_ready  in   decode consumes the head this cycle
//   stall_cnt  out  saturating count of cycles with out_valid & ~out_ready
//   dbg_state  out  FSM state (0 EMPTY, 1 ONE, 2 FULL) for checkers
// -----------------------------------------------------------------------------
module if_id_skid_buffer #(
  parameter int unsigned               INSTR_W   = 16,
  parameter int unsigned               PC_W      = 14,
  parameter logic [INSTR_W-1:0]        NOP_INSTR = 16'h0000,
  parameter int unsigned               CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] head_instr_q, head_instr_d;
  logic [PC_W-1:0]    head_pc_q, head_pc_d;
  logic [INSTR_W-1:0] tail_instr_q, tail_instr_d;
  logic [PC_W-1:0]    tail_pc_q, tail_pc_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  // Goes high on the first edge after reset release, so in_ready stays low
  // for that first cycle and drops immediately when reset is asserted.
  logic               run_q;

  logic acc;
  logic pop;

  assign in_ready  = (state_q != FULL) & run_q;
  assign out_valid = (state_q != EMPTY);
  assign acc       = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  // Stale head contents are never exposed while the buffer is empty.
  assign out_instr = out_valid ? head_instr_q : NOP_INSTR;
  assign out_pc    = out_valid ? head_pc_q    : '0;
  assign stall_cnt = stall_cnt_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d      = state_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
    if (flush) begin
      // Highest priority: a same-cycle pop counts as consumed but its data
      // is squashed by decode; a same-cycle input is dropped (acc is low).
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d      = ONE;
            head_instr_d = in_instr;
            head_pc_d    = in_pc;
          end
        end
        ONE: begin
          if (acc && pop) begin
            head_instr_d = in_instr;
            head_pc_d    = in_pc;
          end else if (acc) begin
            state_d      = FULL;
            tail_instr_d = in_instr;
            tail_pc_d    = in_pc;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can change state.
          if (pop) begin
            state_d      = ONE;
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= EMPTY;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      tail_instr_q <= '0;
      tail_pc_q    <= '0;
      stall_cnt_q  <= '0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
      stall_cnt_q  <= stall_cnt_d;
      run_q        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_if_id_skid_buffer
//
// Bench for if_id_skid_buffer. A reference model (entry queue, ready enable,
// saturating stall counter) predicts every output; stimulus is applied on the
// falling edge and outputs are compared there, away from the active edge.
// -----------------------------------------------------------------------------
module tb_if_id_skid_buffer;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 14;
  localparam int unsigned CNT_W   = 4;
  localparam logic [INSTR_W-1:0] NOP = 16'h0000;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               in_ready;
  logic               flush;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic               out_ready;
  logic [CNT_W-1:0]   stall_cnt;
  logic [1:0]         dbg_state;

  if_id_skid_buffer #(
    .INSTR_W  (INSTR_W),
    .PC_W     (PC_W),
    .NOP_INSTR(NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .in_ready (in_ready),
    .flush    (flush),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc   (out_pc),
    .out_ready(out_ready),
    .stall_cnt(stall_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic [INSTR_W+PC_W-1:0] exp_q[$];
  int unsigned             m_stall;
  bit                      m_run;
  int                      vectors;
  int                      miscompares;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_stall = 0;
    m_run   = 1'b0;
  endtask

  task automatic check_outputs();
    logic [INSTR_W+PC_W-1:0] head;
    bit                      m_valid;
    m_valid = (exp_q.size() != 0);
    if (m_valid) head = exp_q[0];
    else         head = {NOP, {PC_W{1'b0}}};
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("in_ready",  {31'd0, in_ready},  {31'd0, (m_run && exp_q.size() < 2)});
    check("state",     {30'd0, dbg_state}, exp_q.size());
    check("out_instr", {16'd0, out_instr}, {16'd0, head[INSTR_W+PC_W-1:PC_W]});
    check("out_pc",    {18'd0, out_pc},    {18'd0, head[PC_W-1:0]});
    check("stall_cnt", {28'd0, stall_cnt}, m_stall);
  endtask

  // ---------------- driver ----------------
  // Called on a falling edge: drive, compare, advance one clock, update model.
  task automatic step(input bit v, input logic [INSTR_W-1:0] instr,
                      input logic [PC_W-1:0] pc, input bit ordy, input bit fl);
    bit m_ready, acc, pop, stall;
    in_valid  = v;
    in_instr  = v ? instr : 'x;
    in_pc     = v ? pc    : 'x;
    out_ready = ordy;
    flush     = fl;
    check_outputs();
    m_ready = m_run && (exp_q.size() < 2);
    acc     = v && m_ready && !fl;
    pop     = (exp_q.size() != 0) && ordy;
    stall   = (exp_q.size() != 0) && !ordy && !fl;
    @(posedge clk);
    if (fl) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({instr, pc});
    end
    if (stall && m_stall != 15) m_stall++;
    m_run = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, '0, '0, ordy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
    idle(1'b1);   // in_ready still 0 before the first edge after release

    // T1 stream
    step(1'b1, 16'h1111, 14'd0, 1'b1, 1'b0);
    step(1'b1, 16'h2222, 14'd4, 1'b1, 1'b0);
    step(1'b1, 16'h3333, 14'd8, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // T2 backpressure / fill
    step(1'b1, 16'hA001, 14'h10, 1'b0, 1'b0);
    step(1'b1, 16'hA002, 14'h14, 1'b0, 1'b0);
    step(1'b1, 16'hA003, 14'h18, 1'b0, 1'b0); // refused: FULL
    idle(1'b0);
    idle(1'b0);

    // T3 drain
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // T4 flush priority
    step(1'b1, 16'hC001, 14'h20, 1'b0, 1'b0);
    step(1'b1, 16'hC002, 14'h24, 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 14'h28, 1'b1, 1'b1);
    check("no_beef", {31'd0, (out_instr == 16'hBEEF)}, 32'd0);
    idle(1'b1);

    // T5 simultaneous accept + pop in ONE
    step(1'b1, 16'h0101, 14'h30, 1'b0, 1'b0);
    step(1'b1, 16'h0202, 14'h34, 1'b1, 1'b0);
    check("t5_head", {16'd0, out_instr}, 32'h0202);
    idle(1'b1);

    // T6 async reset mid-operation while FULL
    step(1'b1, 16'hD001, 14'h40, 1'b0, 1'b0);
    step(1'b1, 16'hD002, 14'h44, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_state",     {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(1'b0);

    // Saturation
    step(1'b1, 16'hE001, 14'h50, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b0);
    check("stall_sat", {28'd0, stall_cnt}, 32'h0000_000F);
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'b1 & ($urandom_range(0, 3) != 0),
           INSTR_W'($urandom_range(0, 16'hFFFF)),
           PC_W'($urandom_range(0, 14'h3FFF)),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
